// File: rtl/kl10_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kl10_serial_pkg
// Description : Shared types and helpers for the KL10 serial word link receive
//               path: deserializer FSM state type and bit-counter sizing.
// Contents    : des_state_t  - IDLE (no word in progress) / SHIFT (partial word)
//               cnt_width()  - bits needed to count 0..width inclusive
// Revision    : 1.0 - initial release
// ============================================================================
package kl10_serial_pkg;

  typedef enum logic {
    DES_IDLE  = 1'b0,
    DES_SHIFT = 1'b1
  } des_state_t;

  // Counter must be able to hold the value WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage : kl10_serial_pkg
`default_nettype wire

// File: rtl/serial_shift_in_reg.sv
`default_nettype none
// ============================================================================
// Module      : serial_shift_in_reg
// Description : Assembly shift register for the serial word receiver. Shifts
//               one bit per enabled cycle; CLRLOAD discards the old contents
//               so the incoming bit becomes the first bit of a fresh word.
// Ports       : CLK      in  1      clock, posedge
//               RESET    in  1      synchronous active-high reset
//               SIN      in  1      serial data bit
//               EN       in  1      shift enable
//               CLRLOAD  in  1      with EN: clear then shift SIN in
//               Q        out WIDTH  assembly register [0:WIDTH-1]
// Revision    : 1.0 - initial release
// ============================================================================
module serial_shift_in_reg
  import kl10_serial_pkg::*;
#(
  parameter int unsigned WIDTH     = 36,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             SIN,
  input  logic             EN,
  input  logic             CLRLOAD,
  output logic [0:WIDTH-1] Q
);

  logic [0:WIDTH-1] asm_q;
  logic [0:WIDTH-1] asm_d;
  logic [0:WIDTH-1] base;

  assign base = CLRLOAD ? '0 : asm_q;

  generate
    if (WIDTH == 1) begin : g_single
      assign asm_d = SIN;
    end else if (MSB_FIRST) begin : g_msb_first
      // First bit travels toward index 0 as later bits arrive.
      assign asm_d = {base[1:WIDTH-1], SIN};
    end else begin : g_lsb_first
      // First bit travels toward index WIDTH-1 as later bits arrive.
      assign asm_d = {SIN, base[0:WIDTH-2]};
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RESET) begin
      asm_q <= '0;
    end else if (EN) begin
      asm_q <= asm_d;
    end
  end

  assign Q = asm_q;

endmodule : serial_shift_in_reg
`default_nettype wire

// File: rtl/serial_word_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : serial_word_deserializer
// Description : Receive end of the serial word link. Collects a FRAME-marked
//               serial bit stream into a WIDTH-bit word and presents it on a
//               valid/ready output with one holding register, so the next
//               word can assemble while the previous one waits.
// Ports       : CLK       in  1      clock, posedge
//               RESET     in  1      synchronous active-high reset
//               SIN       in  1      serial data bit
//               SEN       in  1      shift enable, one bit per SEN cycle
//               FRAME     in  1      start of frame (qualified by SEN)
//               Q         out WIDTH  assembled word [0:WIDTH-1], bit 0 = MSB
//               QVALID    out 1      Q holds an undelivered word
//               QREADY    in  1      consumer accepts Q on QVALID&&QREADY
//               OVERRUN   out 1      sticky: completed word dropped
//               FRAMEERR  out 1      sticky: FRAME with partial word pending
//               CLR_ERR   in  1      clears the sticky flags
// Revision    : 1.0 - initial release
// ============================================================================
module serial_word_deserializer
  import kl10_serial_pkg::*;
#(
  parameter int unsigned WIDTH     = 36,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             SIN,
  input  logic             SEN,
  input  logic             FRAME,
  output logic [0:WIDTH-1] Q,
  output logic             QVALID,
  input  logic             QREADY,
  output logic             OVERRUN,
  output logic             FRAMEERR,
  input  logic             CLR_ERR
);

  localparam int unsigned     CW     = cnt_width(WIDTH);
  localparam logic [CW-1:0]   C_LAST = CW'(WIDTH - 1);

  des_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [0:WIDTH-1] q_q, q_d;
  logic             qvalid_q, qvalid_d;
  logic             ovr_q, ovr_d;
  logic             ferr_q, ferr_d;

  logic [0:WIDTH-1] asm;
  logic [0:WIDTH-1] word;
  logic             frame_start;
  logic             shift_bit;
  logic             complete;
  logic             load_out;
  logic             drop_word;
  logic             ferr_set;

  assign frame_start = SEN & FRAME;
  assign shift_bit   = SEN & ~FRAME & (state_q == DES_SHIFT);
  assign ferr_set    = frame_start & (state_q == DES_SHIFT);

  serial_shift_in_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_asm (
    .CLK     (CLK),
    .RESET   (RESET),
    .SIN     (SIN),
    .EN      (frame_start | shift_bit),
    .CLRLOAD (frame_start),
    .Q       (asm)
  );

  // The completed word is the assembly register after this edge's shift,
  // rebuilt here so it can land in Q on the same edge as its last bit.
  generate
    if (WIDTH == 1) begin : g_word_single
      assign word = SIN;
    end else if (MSB_FIRST) begin : g_word_msb_first
      assign word = {asm[1:WIDTH-1], SIN};
    end else begin : g_word_lsb_first
      assign word = {SIN, asm[0:WIDTH-2]};
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    if (frame_start) begin
      if (WIDTH == 1) begin
        complete = 1'b1;
        state_d  = DES_IDLE;
        cnt_d    = '0;
      end else begin
        state_d = DES_SHIFT;
        cnt_d   = CW'(1);
      end
    end else if (shift_bit) begin
      if (cnt_q == C_LAST) begin
        complete = 1'b1;
        state_d  = DES_IDLE;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // An accept on the completion edge frees the holding register in time.
  assign load_out  = complete & (~qvalid_q | QREADY);
  assign drop_word = complete & qvalid_q & ~QREADY;

  always_comb begin
    q_d      = load_out ? word : q_q;
    qvalid_d = qvalid_q;
    if (load_out) begin
      qvalid_d = 1'b1;
    end else if (qvalid_q & QREADY) begin
      qvalid_d = 1'b0;
    end
    // A new error in the clear cycle still sets the flag.
    ovr_d  = (ovr_q  & ~CLR_ERR) | drop_word;
    ferr_d = (ferr_q & ~CLR_ERR) | ferr_set;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= DES_IDLE;
      cnt_q    <= '0;
      q_q      <= '0;
      qvalid_q <= 1'b0;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      q_q      <= q_d;
      qvalid_q <= qvalid_d;
      ovr_q    <= ovr_d;
      ferr_q   <= ferr_d;
    end
  end

  assign Q        = q_q;
  assign QVALID   = qvalid_q;
  assign OVERRUN  = ovr_q;
  assign FRAMEERR = ferr_q;

endmodule : serial_word_deserializer
`default_nettype wire

// File: tb/tb_serial_word_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_word_deserializer
// Description : Self-checking bench for serial_word_deserializer. Three
//               instances (36-bit MSB-first, 8-bit MSB-first, 8-bit
//               LSB-first) share the stimulus; each is tracked by a bit-list
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_word_deserializer;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RESET, SIN, SEN, FRAME, QREADY, CLR_ERR;

  logic [0:35] q36;
  logic [0:7]  q8, q8l;
  logic        v36, v8, v8l, ov36, ov8, ov8l, fe36, fe8, fe8l;

  serial_word_deserializer #(.WIDTH(36), .MSB_FIRST(1'b1)) u_dut36 (
    .CLK(CLK), .RESET(RESET), .SIN(SIN), .SEN(SEN), .FRAME(FRAME),
    .Q(q36), .QVALID(v36), .QREADY(QREADY), .OVERRUN(ov36),
    .FRAMEERR(fe36), .CLR_ERR(CLR_ERR));

  serial_word_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut8 (
    .CLK(CLK), .RESET(RESET), .SIN(SIN), .SEN(SEN), .FRAME(FRAME),
    .Q(q8), .QVALID(v8), .QREADY(QREADY), .OVERRUN(ov8),
    .FRAMEERR(fe8), .CLR_ERR(CLR_ERR));

  serial_word_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut8l (
    .CLK(CLK), .RESET(RESET), .SIN(SIN), .SEN(SEN), .FRAME(FRAME),
    .Q(q8l), .QVALID(v8l), .QREADY(QREADY), .OVERRUN(ov8l),
    .FRAMEERR(fe8l), .CLR_ERR(CLR_ERR));

  int ncmp  = 0;
  int nfail = 0;

  // Reference model: received bits kept in arrival order (acc[0] = first).
  int          mw [3] = '{36, 8, 8};
  int          mm [3] = '{1, 1, 0};
  int          mcnt [3];
  logic [63:0] macc [3];
  logic [63:0] mq [3];
  logic        mv [3];
  logic        mov [3];
  logic        mfe [3];

  typedef struct {
    logic       rst, sen, frame, sin, qr, clr;
    logic [7:0] eq;
    logic       ev, eov, efe;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mkv(input logic rst, sen, frame, sin, qr, clr,
                               input logic [7:0] eq, input logic ev, eov, efe);
    vec_t v;
    v.rst = rst; v.sen = sen; v.frame = frame; v.sin = sin; v.qr = qr; v.clr = clr;
    v.eq = eq; v.ev = ev; v.eov = eov; v.efe = efe;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // First received bit is Q[0] (numeric MSB) when MSB-first, else Q[w-1].
  function automatic logic [63:0] mk_word(input logic [63:0] acc, input int w, input int msbf);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      if (msbf != 0) r[w-1-i] = acc[i];
      else           r[i]     = acc[i];
    end
    return r;
  endfunction

  task automatic model_edge();
    for (int d = 0; d < 3; d++) begin
      if (RESET) begin
        mcnt[d] = 0; macc[d] = '0; mq[d] = '0;
        mv[d] = 1'b0; mov[d] = 1'b0; mfe[d] = 1'b0;
      end else begin
        logic done, ov_n, fe_n, accept;
        done = 1'b0; ov_n = 1'b0; fe_n = 1'b0;
        accept = mv[d] & QREADY;
        if (SEN && FRAME) begin
          if (mcnt[d] > 0) fe_n = 1'b1;
          macc[d] = '0;
          macc[d][0] = SIN;
          mcnt[d] = 1;
        end else if (SEN && mcnt[d] > 0) begin
          macc[d][mcnt[d]] = SIN;
          mcnt[d]++;
        end
        if (mcnt[d] == mw[d]) begin
          done = 1'b1;
          mcnt[d] = 0;
        end
        if (done) begin
          if (!mv[d] || QREADY) begin
            mq[d] = mk_word(macc[d], mw[d], mm[d]);
            mv[d] = 1'b1;
          end else begin
            ov_n = 1'b1;
          end
        end else if (accept) begin
          mv[d] = 1'b0;
        end
        mov[d] = (mov[d] & ~CLR_ERR) | ov_n;
        mfe[d] = (mfe[d] & ~CLR_ERR) | fe_n;
      end
    end
  endtask

  task automatic compare_models();
    logic [63:0] dq [3];
    logic        dv [3], dov [3], dfe [3];
    dq[0] = 64'(q36); dq[1] = 64'(q8); dq[2] = 64'(q8l);
    dv[0] = v36;  dv[1] = v8;  dv[2] = v8l;
    dov[0] = ov36; dov[1] = ov8; dov[2] = ov8l;
    dfe[0] = fe36; dfe[1] = fe8; dfe[2] = fe8l;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("model%0d_qvalid", d), 64'(dv[d]), 64'(mv[d]));
      check($sformatf("model%0d_q", d), dq[d], mq[d]);
      check($sformatf("model%0d_overrun", d), 64'(dov[d]), 64'(mov[d]));
      check($sformatf("model%0d_frameerr", d), 64'(dfe[d]), 64'(mfe[d]));
    end
  endtask

  // Inputs change at negedge; outputs are sampled at the following negedge.
  task automatic step(input logic rst, sen, frame, sin, qr, clr);
    RESET = rst; SEN = sen; FRAME = frame; SIN = sin; QREADY = qr; CLR_ERR = clr;
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    compare_models();
  endtask

  // Gap cycles (SEN=0) are inserted before every bit after the first.
  task automatic send_word(input logic [63:0] val, input int w, input int msbf,
                           input int gap, input logic qr, input logic qr_last);
    for (int i = 0; i < w; i++) begin
      logic b;
      b = (msbf != 0) ? val[w-1-i] : val[i];
      if (i > 0) repeat (gap) step(1'b0, 1'b0, 1'b0, 1'b0, qr, 1'b0);
      step(1'b0, 1'b1, (i == 0), b, (i == w-1) ? qr_last : qr, 1'b0);
    end
  endtask

  initial begin
    RESET = 1'b1; SIN = 1'b0; SEN = 1'b0; FRAME = 1'b0; QREADY = 1'b0; CLR_ERR = 1'b0;

    // ---------------- table-driven vectors on the 8-bit MSB-first instance
    tbl[0]  = mkv(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    tbl[1]  = mkv(0, 1, 0, 1, 0, 0, 8'h00, 0, 0, 0); // SEN in IDLE ignored
    tbl[2]  = mkv(0, 0, 1, 1, 0, 0, 8'h00, 0, 0, 0); // FRAME without SEN ignored
    tbl[3]  = mkv(0, 1, 1, 1, 0, 0, 8'h00, 0, 0, 0);
    tbl[4]  = mkv(0, 1, 0, 1, 0, 0, 8'h00, 0, 0, 0);
    tbl[5]  = mkv(0, 1, 0, 1, 0, 0, 8'h00, 0, 0, 0);
    tbl[6]  = mkv(0, 1, 0, 1, 0, 0, 8'h00, 0, 0, 0);
    tbl[7]  = mkv(0, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    tbl[8]  = mkv(0, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    tbl[9]  = mkv(0, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    tbl[10] = mkv(0, 1, 0, 0, 0, 0, 8'hF0, 1, 0, 0); // last bit -> valid
    tbl[11] = mkv(0, 0, 0, 0, 1, 0, 8'hF0, 0, 0, 0); // accept, Q retained
    tbl[12] = mkv(0, 1, 1, 1, 0, 0, 8'hF0, 0, 0, 0);
    tbl[13] = mkv(0, 1, 1, 0, 0, 0, 8'hF0, 0, 0, 1); // FRAME mid-word
    tbl[14] = mkv(0, 0, 0, 0, 0, 1, 8'hF0, 0, 0, 0); // clear
    tbl[15] = mkv(0, 1, 1, 1, 0, 1, 8'hF0, 0, 0, 1); // error beats clear
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].rst, tbl[i].sen, tbl[i].frame, tbl[i].sin, tbl[i].qr, tbl[i].clr);
      check($sformatf("tbl%0d_q", i), 64'(q8), 64'(tbl[i].eq));
      check($sformatf("tbl%0d_qvalid", i), 64'(v8), 64'(tbl[i].ev));
      check($sformatf("tbl%0d_overrun", i), 64'(ov8), 64'(tbl[i].eov));
      check($sformatf("tbl%0d_frameerr", i), 64'(fe8), 64'(tbl[i].efe));
    end

    // ---------------- 36-bit word, valid for exactly one cycle
    step(1, 0, 0, 0, 0, 0);
    send_word(64'(36'o123456701234), 36, 1, 0, 1'b1, 1'b1);
    check("w36_q", 64'(q36), 64'(36'o123456701234));
    check("w36_qvalid", 64'(v36), 64'd1);
    step(0, 0, 0, 0, 1, 0);
    check("w36_qvalid_drop", 64'(v36), 64'd0);

    // ---------------- LSB-first: first bit lands in Q[7]
    step(1, 0, 0, 0, 0, 0);
    send_word(64'h01, 8, 0, 0, 1'b0, 1'b0);
    check("lsbf_q", 64'(q8l), 64'h01);
    check("lsbf_q7", 64'(q8l[7]), 64'd1);

    // ---------------- gapped SEN, held word, overrun, clear
    step(1, 0, 0, 0, 0, 0);
    send_word(64'hA5, 8, 1, 2, 1'b0, 1'b0);
    check("gap_q1", 64'(q8), 64'hA5);
    check("gap_qvalid1", 64'(v8), 64'd1);
    send_word(64'h3C, 8, 1, 2, 1'b0, 1'b0);
    check("ovr_set", 64'(ov8), 64'd1);
    check("ovr_q_held", 64'(q8), 64'hA5);
    check("ovr_qvalid", 64'(v8), 64'd1);
    step(0, 0, 0, 0, 0, 1);
    check("ovr_cleared", 64'(ov8), 64'd0);

    // ---------------- frame error then clean word
    step(1, 0, 0, 0, 0, 0);
    send_word(64'h1F, 5, 1, 0, 1'b1, 1'b1);
    send_word(64'hF0, 8, 1, 0, 1'b1, 1'b1);
    check("ferr_set", 64'(fe8), 64'd1);
    check("ferr_q", 64'(q8), 64'hF0);
    check("ferr_qvalid", 64'(v8), 64'd1);

    // ---------------- accept on completion edge keeps QVALID high
    step(1, 0, 0, 0, 0, 0);
    send_word(64'h11, 8, 1, 0, 1'b0, 1'b0);
    check("b2b_q1", 64'(q8), 64'h11);
    send_word(64'h22, 8, 1, 0, 1'b0, 1'b1);
    check("b2b_q2", 64'(q8), 64'h22);
    check("b2b_qvalid", 64'(v8), 64'd1);
    check("b2b_overrun", 64'(ov8), 64'd0);
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 1, 0, 0);
    check("idle_sen_nothing", 64'(v8), 64'd0);

    // ---------------- reset mid-word with a held word and flags set
    step(1, 0, 0, 0, 0, 0);
    send_word(64'h11, 8, 1, 0, 1'b0, 1'b0);
    step(0, 1, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    step(0, 1, 0, 1, 0, 0);
    check("pre_rst_ferr", 64'(fe8), 64'd1);
    step(1, 1, 0, 1, 1, 0);
    check("rst_qvalid", 64'(v8), 64'd0);
    check("rst_q", 64'(q8), 64'd0);
    check("rst_flags", 64'({ov8, fe8}), 64'd0);
    send_word(64'h81, 8, 1, 0, 1'b0, 1'b0);
    check("post_rst_q", 64'(q8), 64'h81);
    check("post_rst_qvalid", 64'(v8), 64'd1);

    // ---------------- randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 9) == 0),
           1'($urandom),
           1'($urandom),
           ($urandom_range(0, 19) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule : tb_serial_word_deserializer
`default_nettype wire
